// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, CCR bit positions and width defaults for the ALU execute stage
package exec_pkg;
  localparam int DW_DEF = 16;
  localparam int RW_DEF = 3;
  localparam int PCW_DEF = 32;
  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;
  typedef enum logic [3:0] {
    OP_NOP, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_INC,
    OP_DEC, OP_SHL, OP_SHR, OP_SETC, OP_CLRC, OP_MUL, OP_PASS, OP_NOP15
  } alu_op_e;
  typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_e;
  function automatic logic writes_zn(input logic [3:0] op);
    return !(op inside {OP_NOP, OP_SETC, OP_CLRC, OP_NOP15});
  endfunction
  function automatic logic writes_c(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_SHL, OP_SHR, OP_MUL};
  endfunction
endpackage

// File: rtl/alu_exec_stage_mul.sv
// serial_mul16: shift-add multiplier, one partial product per cycle; ports start/abort, a/b in, busy/last/product/overflow out
module serial_mul16 import exec_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic          o_busy,
  output logic          o_last,
  output logic [DW-1:0] o_product,
  output logic          o_overflow
);
  localparam int CW = $clog2(DW) + 1;
  mul_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2*DW-1:0] acc_q, acc_d, mcand_q, mcand_d, sum;
  logic [DW-1:0] mplier_q, mplier_d;
  always_ff @(posedge clk) begin
    if (rst) state_q <= MUL_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == MUL_IDLE && i_start) state_d = MUL_BUSY;
    if (state_q == MUL_BUSY && (i_abort || count_q == CW'(1))) state_d = MUL_IDLE;
  end
  // the product is taken from sum so the last partial product lands in the completing cycle
  always_comb begin
    sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    o_busy = state_q == MUL_BUSY;
    o_last = o_busy && count_q == CW'(1);
    o_product = sum[DW-1:0];
    o_overflow = |sum[2*DW-1:DW];
  end
  always_comb begin
    count_d = count_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    if (state_q == MUL_IDLE && i_start) begin
      count_d = CW'(DW);
      acc_d = '0;
      mcand_d = {{DW{1'b0}}, i_a};
      mplier_d = i_b;
    end else if (state_q == MUL_BUSY) begin
      count_d = count_q - CW'(1);
      acc_d = sum;
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
    end else begin
      count_q <= count_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
    end
  end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: forwarding, ALU, CCR {C,N,Z} and ALU/MEM output registers; o_stall holds the upstream buffer during MUL
module alu_exec_stage import exec_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int PCW = PCW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_valid,
  input  logic           i_flush,
  input  logic           i_wb,
  input  logic           i_mem,
  input  logic           i_chg_flag,
  input  logic [3:0]     i_alu_op,
  input  logic           i_use_immd,
  input  logic [PCW-1:0] i_pc,
  input  logic [RW-1:0]  i_rsrc1,
  input  logic [RW-1:0]  i_rsrc2,
  input  logic [RW-1:0]  i_rdst,
  input  logic [DW-1:0]  i_read_data1,
  input  logic [DW-1:0]  i_read_data2,
  input  logic [DW-1:0]  i_immd,
  input  logic           i_exmem_wb,
  input  logic           i_memwb_wb,
  input  logic [RW-1:0]  i_exmem_rdst,
  input  logic [RW-1:0]  i_memwb_rdst,
  input  logic [DW-1:0]  i_exmem_result,
  input  logic [DW-1:0]  i_memwb_result,
  output logic           o_stall,
  output logic           o_valid,
  output logic           o_wb,
  output logic           o_mem,
  output logic [DW-1:0]  o_result,
  output logic [DW-1:0]  o_store_data,
  output logic [RW-1:0]  o_rdst,
  output logic [PCW-1:0] o_pc,
  output logic [2:0]     o_ccr
);
  logic [DW-1:0] a, fwd2, b, alu_r, mul_product, result_q, result_d, store_data_q, store_data_d;
  logic [DW:0] sh;
  logic alu_c, is_mul, mul_busy, mul_last, mul_ovf, done;
  logic valid_q, valid_d, wb_q, wb_d, mem_q, mem_d;
  logic [RW-1:0] rdst_q, rdst_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [2:0] ccr_q, ccr_d;
  assign a = (i_exmem_wb && i_exmem_rdst == i_rsrc1) ? i_exmem_result :
             (i_memwb_wb && i_memwb_rdst == i_rsrc1) ? i_memwb_result : i_read_data1;
  assign fwd2 = (i_exmem_wb && i_exmem_rdst == i_rsrc2) ? i_exmem_result :
                (i_memwb_wb && i_memwb_rdst == i_rsrc2) ? i_memwb_result : i_read_data2;
  assign b = i_use_immd ? i_immd : fwd2;
  assign is_mul = i_alu_op == OP_MUL;
  serial_mul16 #(.DW(DW)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_valid & is_mul & ~i_flush),
    .i_abort   (i_flush),
    .i_a       (a),
    .i_b       (b),
    .o_busy    (mul_busy),
    .o_last    (mul_last),
    .o_product (mul_product),
    .o_overflow(mul_ovf)
  );
  // while busy the held inputs are ignored except for flush; completion is the count==1 cycle
  assign o_stall = ~rst & ~i_flush & (mul_busy ? ~mul_last : i_valid & is_mul);
  assign done = mul_busy ? mul_last & ~i_flush : i_valid & ~i_flush & ~is_mul;
  // alu_c defaults to the current C so a zero-distance shift leaves it unchanged
  always_comb begin
    alu_r = '0;
    alu_c = ccr_q[CCR_C];
    sh = '0;
    case (i_alu_op)
      OP_MOV: alu_r = a;
      OP_ADD: {alu_c, alu_r} = {1'b0, a} + {1'b0, b};
      OP_SUB: {alu_c, alu_r} = {1'b0, a} - {1'b0, b};
      OP_AND: alu_r = a & b;
      OP_OR: alu_r = a | b;
      OP_NOT: alu_r = ~a;
      OP_INC: {alu_c, alu_r} = {1'b0, a} + {{DW{1'b0}}, 1'b1};
      OP_DEC: {alu_c, alu_r} = {1'b0, a} - {{DW{1'b0}}, 1'b1};
      OP_SHL: begin
        sh = {1'b0, a} << b[3:0];
        alu_r = sh[DW-1:0];
        alu_c = |b[3:0] ? sh[DW] : alu_c;
      end
      OP_SHR: begin
        sh = {a, 1'b0} >> b[3:0];
        alu_r = sh[DW:1];
        alu_c = |b[3:0] ? sh[0] : alu_c;
      end
      OP_MUL: {alu_c, alu_r} = {mul_ovf, mul_product};
      OP_PASS: alu_r = b;
      default: ;
    endcase
  end
  always_comb begin
    valid_d = done;
    wb_d = done & i_wb;
    mem_d = done & i_mem;
    result_d = alu_r;
    store_data_d = fwd2;
    rdst_d = i_rdst;
    pc_d = i_pc;
    ccr_d[CCR_Z] = done && i_chg_flag && writes_zn(i_alu_op) ? ~|alu_r : ccr_q[CCR_Z];
    ccr_d[CCR_N] = done && i_chg_flag && writes_zn(i_alu_op) ? alu_r[DW-1] : ccr_q[CCR_N];
    ccr_d[CCR_C] = done && i_alu_op == OP_SETC ? 1'b1 :
                   done && i_alu_op == OP_CLRC ? 1'b0 :
                   done && i_chg_flag && writes_c(i_alu_op) ? alu_c : ccr_q[CCR_C];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      wb_q <= 1'b0;
      mem_q <= 1'b0;
      result_q <= '0;
      store_data_q <= '0;
      rdst_q <= '0;
      pc_q <= '0;
      ccr_q <= '0;
    end else begin
      valid_q <= valid_d;
      wb_q <= wb_d;
      mem_q <= mem_d;
      result_q <= result_d;
      store_data_q <= store_data_d;
      rdst_q <= rdst_d;
      pc_q <= pc_d;
      ccr_q <= ccr_d;
    end
  end
  assign o_valid = valid_q;
  assign o_wb = wb_q;
  assign o_mem = mem_q;
  assign o_result = result_q;
  assign o_store_data = store_data_q;
  assign o_rdst = rdst_q;
  assign o_pc = pc_q;
  assign o_ccr = ccr_q;
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Consumer side of the decode/ALU pipeline buffer: takes the registered decode fields, resolves operands through forwarding, and executes the ALU operation. It keeps the condition-code register (Z, N, C) and registers its results into the ALU/memory boundary. Multiply is serial and multi-cycle; the block drives o_stall so that the upstream buffer holds (upstream enable = ~o_stall).

Parameters:
DW, 16, datapath width
RW, 3, register index width
PCW, 32, program counter width

Ports:
clk  in  1  clock
rst  in  1  reset
i_valid  in  1  instruction present (0 = bubble)
i_flush  in  1  squash current instruction and in-flight multiply
i_wb, i_mem, i_chg_flag  in  1 each  control bits from decode
i_alu_op  in  4  operation code
i_use_immd  in  1  operand B = i_immd instead of forwarded src2
i_pc  in  PCW  instruction PC
i_rsrc1, i_rsrc2, i_rdst  in  RW each  register indices
i_read_data1, i_read_data2, i_immd  in  DW each  register-file operands, immediate
i_exmem_wb, i_memwb_wb  in  1 each  later-stage write-back valid
i_exmem_rdst, i_memwb_rdst  in  RW each  later-stage destinations
i_exmem_result, i_memwb_result  in  DW each  later-stage values
o_stall  out  1  hold upstream, combinational
o_valid, o_wb, o_mem  out  1 each  registered
o_result, o_store_data  out  DW each  registered ALU result, forwarded src2
o_rdst  out  RW  registered
o_pc  out  PCW  registered
o_ccr  out  3  {C,N,Z}, registered

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. rst wins over all other inputs. On reset all outputs = 0, CCR = 0, FSM = IDLE, o_stall = 0. A reset during a multiply aborts it.
- Forwarding per source: the ex/mem value is used if i_exmem_wb and i_exmem_rdst match. Otherwise the mem/wb value is used if i_memwb_wb and i_memwb_rdst match. Otherwise i_read_data is used. Ex/mem has priority. All 8 registers are forwardable.
- Opcodes:
  - 0 NOP
  - 1 MOV = A
  - 2 ADD = A+B
  - 3 SUB = A-B
  - 4 AND
  - 5 OR
  - 6 NOT A
  - 7 INC A
  - 8 DEC A
  - 9 SHL A by B[3:0]
  - 10 SHR (logical) A by B[3:0]
  - 11 SETC
  - 12 CLRC
  - 13 MUL, low DW bits
  - 14 PASS = B
  - 15 = NOP
- Width and carry rules: arithmetic is DW+1 wide. C = carry-out for ADD and INC. For SUB and DEC, C = borrow (A<B unsigned). For SHL, C = last bit shifted out; for SHR, the same. A shift by 0 leaves C unchanged. For MUL, C = (high DW bits != 0).
- Flag update: Z and N are updated from the result only when i_chg_flag and the instruction completes. C follows the same condition for ops 2,3,7,8,9,10,13. SETC and CLRC always write C. NOP/15 never write the CCR.
- Non-MUL latency: 1 cycle. Outputs register at the next edge. o_valid = i_valid & ~i_flush & ~o_stall.
- FSM IDLE:
  - i_valid & op==MUL & ~i_flush: o_stall = 1 in this same cycle.
  - Latch the forwarded A and B, acc = 0, count = 16, go to BUSY.
  - Output register takes a bubble (o_valid = 0).
- FSM BUSY:
  - One shift-add per cycle; count decrements.
  - o_stall = 1 while count > 1.
  - In the cycle count == 1: o_stall = 0, the final product and CCR are registered, o_valid = 1, return to IDLE.
- Multiply timing: o_stall is high for exactly 16 cycles. The result appears on the 17th edge after MUL is presented. Inputs are ignored in BUSY; the buffer holds them.
- Flush: i_flush in IDLE causes a bubble next cycle and no CCR write. i_flush in BUSY aborts to IDLE with o_stall = 0 in that cycle, a bubble output, and no CCR write.
- Back-to-back MUL: a second MUL is accepted in the cycle after completion.

Decomposition:
- Package exec_pkg: opcode constants, CCR bit indices (Z=0, N=1, C=2), DW/RW defaults.
- Sub-module serial_mul16 (start, A, B, busy, last, product, overflow) holds the FSM and counter. The stage keeps forwarding, ALU, CCR and output registers.

Test Plan:
- ADD A=0xFFFF, B=0x0001, chg_flag=1 -> o_result=0x0000, o_ccr={C=1,N=0,Z=1} after 1 cycle.
- Forwarding: rsrc1=3 with exmem(wb=1, rdst=3, 0x0010) and memwb(wb=1, rdst=3, 0x0020), read_data1=0x0030, MOV -> o_result=0x0010. With exmem_wb=0 -> 0x0020.
- MUL 0x0300×0x0100 -> o_stall high 16 cycles, o_valid=1 on the 17th edge, o_result=0x0000, C=1. Then 0x0012×0x0003 -> 0x0036, C=0.
- SHL A=0x8001 by 1, chg_flag=1 -> 0x0002, C=1. SHL by 0 -> C unchanged. SETC then CLRC -> C=1, then C=0.
- i_flush at BUSY cycle 5 of a MUL -> o_stall=0 that cycle, o_valid=0, CCR unchanged, next ADD accepted.
- rst at BUSY cycle 8 -> all outputs 0, o_stall=0 next cycle. A MUL presented after reset completes in 17 edges.
